// File: rtl/c64_bus_arbiter.sv
// Bus ownership sequencer for the shared C64 system bus: CPU, VIC-II DMA, expansion DMA.
// Latency: all outputs are registered and change only on clk edges with cyc_tick=1; aec falls BA_DELAY ticks after rdy.
// Backpressure: requesters are level-sensitive and hold their request until granted; the CPU is stalled via rdy/aec.
//
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   cyc_tick        - one-clk pulse per CPU bus cycle; the only enable for state changes
//   vic_req/ext_req - level bus requests (VIC has priority over EXT)
//   rdy, aec        - CPU RDY / AEC controls
//   owner           - 0 = CPU, 1 = VIC, 2 = EXT
//   vic_grant/ext_grant - bus granted to VIC / EXT (only while aec=0)
//   stolen_cnt      - free-running count of bus cycles completed with aec=0
module c64_bus_arbiter #(
   parameter int BA_DELAY = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cyc_tick,
   input  logic             vic_req,
   input  logic             ext_req,
   output logic             rdy,
   output logic             aec,
   output logic [1:0]       owner,
   output logic             vic_grant,
   output logic             ext_grant,
   output logic [CNT_W-1:0] stolen_cnt
);

   localparam logic [1:0] SRC_CPU = 2'd0;
   localparam logic [1:0] SRC_VIC = 2'd1;
   localparam logic [1:0] SRC_EXT = 2'd2;

   // Counter only needs to hold BA_DELAY-1.
   localparam int WC_W = (BA_DELAY > 1) ? $clog2(BA_DELAY) : 1;
   localparam logic [WC_W-1:0] WC_INIT = (BA_DELAY > 0) ? WC_W'(BA_DELAY - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_OWN  = 2'd2
   } state_t;

   state_t          state;
   logic [1:0]      src;
   logic [WC_W-1:0] wait_cnt;

   // Requester that would own the bus if arbitrated now (VIC wins ties).
   logic [1:0] req_src;
   assign req_src = vic_req ? SRC_VIC : SRC_EXT;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         src        <= SRC_CPU;
         wait_cnt   <= '0;
         rdy        <= 1'b1;
         aec        <= 1'b1;
         owner      <= SRC_CPU;
         vic_grant  <= 1'b0;
         ext_grant  <= 1'b0;
         stolen_cnt <= '0;
      end else if (cyc_tick) begin
         case (state)
            S_IDLE: begin
               if (vic_req || ext_req) begin
                  src <= req_src;
                  rdy <= 1'b0;
                  if (BA_DELAY == 0) begin
                     state     <= S_OWN;
                     aec       <= 1'b0;
                     owner     <= req_src;
                     vic_grant <= vic_req;
                     ext_grant <= !vic_req;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= WC_INIT;
                  end
               end
            end

            S_WAIT: begin
               if (!vic_req && !ext_req) begin
                  // Everyone withdrew: give the CPU its bus back.
                  state <= S_IDLE;
                  src   <= SRC_CPU;
                  rdy   <= 1'b1;
               end else begin
                  // Source may switch between VIC and EXT without restarting
                  // the countdown; the CPU has already been warned via rdy.
                  src <= req_src;
                  if (wait_cnt == '0) begin
                     state     <= S_OWN;
                     aec       <= 1'b0;
                     owner     <= req_src;
                     vic_grant <= vic_req;
                     ext_grant <= !vic_req;
                  end else begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end
               end
            end

            S_OWN: begin
               // The cycle just completed ran with aec=0.
               stolen_cnt <= stolen_cnt + 1'b1;
               if (src == SRC_EXT && vic_req) begin
                  // CPU is already off the bus, so VIC takes over immediately.
                  src       <= SRC_VIC;
                  owner     <= SRC_VIC;
                  vic_grant <= 1'b1;
                  ext_grant <= 1'b0;
               end else if ((src == SRC_VIC && !vic_req) ||
                            (src == SRC_EXT && !ext_req)) begin
                  // Always return to the CPU for at least one cycle, even if
                  // EXT is waiting behind a finished VIC burst.
                  state     <= S_IDLE;
                  src       <= SRC_CPU;
                  rdy       <= 1'b1;
                  aec       <= 1'b1;
                  owner     <= SRC_CPU;
                  vic_grant <= 1'b0;
                  ext_grant <= 1'b0;
               end
            end

            default: begin
               state     <= S_IDLE;
               src       <= SRC_CPU;
               rdy       <= 1'b1;
               aec       <= 1'b1;
               owner     <= SRC_CPU;
               vic_grant <= 1'b0;
               ext_grant <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Testbench for c64_bus_arbiter: two instances (BA_DELAY=3/CNT_W=16 and BA_DELAY=0/CNT_W=4)
// share stimulus; a cycle-level behavioural model predicts every output after every clk.
// Directed scenarios with explicit expected values are followed by a randomized phase.
module tb_c64_bus_arbiter;

   logic clk = 1'b0;
   logic reset, cyc_tick, vic_req, ext_req;

   logic        rdy0, aec0, vg0, eg0;
   logic [1:0]  own0;
   logic [15:0] cnt0;
   logic        rdy1, aec1, vg1, eg1;
   logic [1:0]  own1;
   logic [3:0]  cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   c64_bus_arbiter #(.BA_DELAY(3), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .cyc_tick(cyc_tick), .vic_req(vic_req), .ext_req(ext_req),
      .rdy(rdy0), .aec(aec0), .owner(own0), .vic_grant(vg0), .ext_grant(eg0), .stolen_cnt(cnt0)
   );

   c64_bus_arbiter #(.BA_DELAY(0), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .cyc_tick(cyc_tick), .vic_req(vic_req), .ext_req(ext_req),
      .rdy(rdy1), .aec(aec1), .owner(own1), .vic_grant(vg1), .ext_grant(eg1), .stolen_cnt(cnt1)
   );

   // Behavioural model, one slot per instance.
   // phase: 0 = CPU on bus, 1 = CPU warned (rdy low), 2 = bus stolen.
   // who:   1 = VIC, 2 = EXT. left: warning cycles still to run.
   int m_phase [2];
   int m_who   [2];
   int m_left  [2];
   int m_cnt   [2];
   int m_delay [2] = '{3, 0};
   int m_mod   [2] = '{65536, 16};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int d, input bit r, input bit t, input bit v, input bit e);
      if (r) begin
         m_phase[d] = 0; m_who[d] = 0; m_left[d] = 0; m_cnt[d] = 0;
      end else if (t) begin
         case (m_phase[d])
            0: if (v || e) begin
                  m_who[d] = v ? 1 : 2;
                  if (m_delay[d] == 0) m_phase[d] = 2;
                  else begin m_phase[d] = 1; m_left[d] = m_delay[d] - 1; end
               end
            1: if (!v && !e) m_phase[d] = 0;
               else begin
                  m_who[d] = v ? 1 : 2;
                  if (m_left[d] == 0) m_phase[d] = 2;
                  else m_left[d]--;
               end
            default: begin
               m_cnt[d] = (m_cnt[d] + 1) % m_mod[d];
               if (m_who[d] == 2 && v) m_who[d] = 1;
               else if ((m_who[d] == 1 && !v) || (m_who[d] == 2 && !e)) m_phase[d] = 0;
            end
         endcase
      end
   endtask

   task automatic compare_model(input int d, input logic r, input logic a, input logic [1:0] o,
                                input logic vg, input logic eg, input logic [15:0] c);
      string p;
      p = (d == 0) ? "m0" : "m1";
      check({p, "_rdy"},   32'(r),  32'(m_phase[d] == 0));
      check({p, "_aec"},   32'(a),  32'(m_phase[d] != 2));
      check({p, "_owner"}, 32'(o),  (m_phase[d] == 2) ? 32'(m_who[d]) : 32'd0);
      check({p, "_vgnt"},  32'(vg), 32'(m_phase[d] == 2 && m_who[d] == 1));
      check({p, "_egnt"},  32'(eg), 32'(m_phase[d] == 2 && m_who[d] == 2));
      check({p, "_cnt"},   32'(c),  32'(m_cnt[d]));
   endtask

   // One clk: drive at negedge, model at posedge, sample 1 time unit after.
   task automatic cyc(input bit r, input bit t, input bit v, input bit e);
      @(negedge clk);
      reset = r; cyc_tick = t; vic_req = v; ext_req = e;
      @(posedge clk);
      model_step(0, r, t, v, e);
      model_step(1, r, t, v, e);
      #1;
      compare_model(0, rdy0, aec0, own0, vg0, eg0, cnt0);
      compare_model(1, rdy1, aec1, own1, vg1, eg1, {12'd0, cnt1});
   endtask

   // One bus cycle: a tick clk followed by a quiet clk.
   task automatic bus_tick(input bit v, input bit e);
      cyc(1'b0, 1'b1, v, e);
      cyc(1'b0, 1'b0, v, e);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; cyc_tick = 1'b0; vic_req = 1'b0; ext_req = 1'b0;
      do_reset();
      check("rst_rdy", 32'(rdy0), 32'd1);
      check("rst_aec", 32'(aec0), 32'd1);
      check("rst_cnt", 32'(cnt0), 32'd0);

      // VIC steal: request at bus cycles 10..17.
      for (int t = 0; t <= 18; t++) begin
         bus_tick(t >= 10 && t <= 17, 1'b0);
         if (t == 10) check("s1_rdy_t10", 32'(rdy0), 32'd0);
         if (t == 12) check("s1_aec_t12", 32'(aec0), 32'd1);
         if (t == 13) begin
            check("s1_aec_t13", 32'(aec0), 32'd0);
            check("s1_own_t13", 32'(own0), 32'd1);
            check("s1_vg_t13",  32'(vg0),  32'd1);
         end
         if (t == 18) begin
            check("s1_rdy_t18", 32'(rdy0), 32'd1);
            check("s1_aec_t18", 32'(aec0), 32'd1);
            check("s1_cnt_t18", 32'(cnt0), 32'd5);
         end
      end

      // Abort during warning.
      do_reset();
      for (int t = 0; t <= 14; t++) begin
         bus_tick(t == 10 || t == 11, 1'b0);
         if (t == 10) check("s2_rdy_t10", 32'(rdy0), 32'd0);
         if (t == 12) check("s2_rdy_t12", 32'(rdy0), 32'd1);
         if (t >= 10) check("s2_aec", 32'(aec0), 32'd1);
      end
      check("s2_cnt", 32'(cnt0), 32'd0);

      // VIC preempts a warned EXT; countdown not restarted.
      do_reset();
      for (int t = 0; t <= 14; t++) begin
         bus_tick(t >= 11, t >= 10);
         if (t == 12) check("s3_aec_t12", 32'(aec0), 32'd1);
         if (t == 13) begin
            check("s3_aec_t13", 32'(aec0), 32'd0);
            check("s3_own_t13", 32'(own0), 32'd1);
         end
      end

      // VIC preempts an owning EXT, then EXT re-arbitrates from IDLE.
      do_reset();
      for (int t = 0; t <= 22; t++) begin
         bus_tick(t == 15 || t == 16, t >= 10);
         if (t == 13) check("s4_own_t13", 32'(own0), 32'd2);
         if (t == 15) begin
            check("s4_own_t15", 32'(own0), 32'd1);
            check("s4_aec_t15", 32'(aec0), 32'd0);
         end
         if (t == 17) begin
            check("s4_rdy_t17", 32'(rdy0), 32'd1);
            check("s4_aec_t17", 32'(aec0), 32'd1);
         end
         if (t == 18) check("s4_rdy_t18", 32'(rdy0), 32'd0);
         if (t == 20) check("s4_aec_t20", 32'(aec0), 32'd1);
         if (t == 21) begin
            check("s4_aec_t21", 32'(aec0), 32'd0);
            check("s4_own_t21", 32'(own0), 32'd2);
         end
      end

      // Reset mid-OWN, with and without a tick alongside.
      for (int k = 0; k < 2; k++) begin
         do_reset();
         for (int t = 0; t < 6; t++) bus_tick(1'b1, 1'b0);
         check("s5_own_pre", 32'(own0), 32'd1);
         cyc(1'b1, k[0], 1'b1, 1'b0);
         check("s5_rdy", 32'(rdy0), 32'd1);
         check("s5_aec", 32'(aec0), 32'd1);
         check("s5_own", 32'(own0), 32'd0);
         check("s5_cnt", 32'(cnt0), 32'd0);
      end

      // Tick gating, then BA_DELAY=0 immediate grant and counter wrap.
      do_reset();
      for (int i = 0; i < 50; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
         check("s6_hold_rdy", 32'(rdy0), 32'd1);
      end
      bus_tick(1'b1, 1'b0);
      check("s6_d0_rdy", 32'(rdy1), 32'd0);
      check("s6_d0_aec", 32'(aec1), 32'd0);
      check("s6_d0_vg",  32'(vg1),  32'd1);
      for (int t = 1; t <= 16; t++) begin
         bus_tick(1'b1, 1'b0);
         if (t == 15) check("s6_cnt_15", 32'(cnt1), 32'd15);
         if (t == 16) check("s6_cnt_wrap", 32'(cnt1), 32'd0);
      end

      // Randomized traffic with sticky requests and rare resets.
      begin
         bit v, e;
         v = 1'b0; e = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) v = ~v;
            if ($urandom_range(0, 9) == 0) e = ~e;
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, v, e);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
